// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEND,
        ST_GAP
    } arb_state_e;

    localparam logic [3:0] HDR_TAG     = 4'hA;
    localparam int         NUM_REQ_MAX = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin winner search: scans from the slot after ptr_i and wraps.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [SEL_W-1:0]   idx_o
);

    logic             found;
    logic [SEL_W-1:0] sel;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sel = SEL_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[sel]) begin
                found      = 1'b1;
                win_o[sel] = 1'b1;
                idx_o      = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding whole messages from NUM_REQ byte streams into one UART tx path.
// Define UART_TX_ARB_HDR_EN to prefix each message with a {HDR_TAG, owner} header byte.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0][7:0] req_data_i,
    input  logic [NUM_REQ-1:0]      req_vld_i,
    input  logic [NUM_REQ-1:0]      req_last_i,
    output logic [NUM_REQ-1:0]      req_rdy_o,
    output logic [7:0]              tx_data_o,
    output logic                    tx_data_vld_o,
    input  logic                    tx_busy_i,
    output logic [NUM_REQ-1:0]      grant_o
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   gidx_q, gidx_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               last_q, last_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_vld_q, tx_vld_d;

    logic [NUM_REQ-1:0] pick_win;
    logic [SEL_W-1:0]   pick_idx;
    logic               hs;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (req_vld_i),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx)
    );

    // Only the owner ever sees ready, and only while the UART can take a byte.
    assign req_rdy_o     = (state_q == ST_SEND && !tx_busy_i) ? grant_q : '0;
    assign hs            = |(req_vld_i & req_rdy_o);
    assign grant_o       = grant_q;
    assign tx_data_o     = tx_data_q;
    assign tx_data_vld_o = tx_vld_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_vld_i) begin
                    grant_d = pick_win;
                    gidx_d  = pick_idx;
`ifdef UART_TX_ARB_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_SEND;
`endif
                end
            end
`ifdef UART_TX_ARB_HDR_EN
            ST_HDR: begin
                if (!tx_busy_i) begin
                    tx_data_d = {HDR_TAG, 4'(gidx_q)};
                    tx_vld_d  = 1'b1;
                    last_d    = 1'b0;
                    state_d   = ST_GAP;
                end
            end
`endif
            ST_SEND: begin
                if (hs) begin
                    tx_data_d = req_data_i[gidx_q];
                    tx_vld_d  = 1'b1;
                    last_d    = req_last_i[gidx_q];
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                // The gap cycle lets the UART raise busy before the next byte is offered.
                if (last_q) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= SEL_W'(NUM_REQ - 1);
            last_q    <= 1'b0;
            tx_data_q <= 8'h00;
            tx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb; honours UART_TX_ARB_HDR_EN when predicting header bytes.
module tb_uart_tx_arb;

    logic            clk;
    logic            rst;
    logic [3:0][7:0] req_data;
    logic [3:0]      req_vld;
    logic [3:0]      req_last;
    logic [3:0]      req_rdy;
    logic [7:0]      tx_data;
    logic            tx_vld;
    logic            busy;
    logic [3:0]      grant;

    uart_tx_arb #(.NUM_REQ(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_data_i    (req_data),
        .req_vld_i     (req_vld),
        .req_last_i    (req_last),
        .req_rdy_o     (req_rdy),
        .tx_data_o     (tx_data),
        .tx_data_vld_o (tx_vld),
        .tx_busy_i     (busy),
        .grant_o       (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Per-requester message sources: bytes head..tail-1 are still to be sent.
    logic [7:0] m_d[4][64];
    logic       m_l[4][64];
    int         head[4];
    int         tail[4];
    bit         rand_busy = 1'b0;

    // Reference arbitration pointer (last served requester).
    int         mptr = 3;

    logic [7:0] exp_d[$];
    logic [3:0] exp_g[$];
    logic [7:0] obs_d[$];
    logic [3:0] obs_g[$];
    int         obs_c[$];
    int         cyc = 0;
    bit         prev_vld = 1'b0;
    int         b2b_err = 0;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                req_vld[i]  = 1'b1;
                req_data[i] = m_d[i][head[i]];
                req_last[i] = m_l[i][head[i]];
            end else begin
                req_vld[i]  = 1'b0;
                req_data[i] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        if (rand_busy) busy = ($urandom_range(3) == 0);
    endtask

    task automatic tick();
        logic [3:0] hs;
        hs = req_vld & req_rdy;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) if (hs[i]) head[i]++;
        if (tx_vld === 1'b1) begin
            if (prev_vld) b2b_err++;
            obs_d.push_back(tx_data);
            obs_g.push_back(grant);
            obs_c.push_back(cyc);
        end
        prev_vld = (tx_vld === 1'b1);
        drive();
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_d.delete(); exp_g.delete();
        obs_d.delete(); obs_g.delete(); obs_c.delete();
        b2b_err = 0;
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        m_d[r][tail[r]] = d;
        m_l[r][tail[r]] = l;
        tail[r]++;
    endtask

    // Predict the output stream: whole messages, owners chosen round-robin after mptr.
    task automatic build_expected();
        int  pos[4];
        int  owner;
        bit  lst;
        for (int i = 0; i < 4; i++) pos[i] = head[i];
        while (1) begin
            owner = -1;
            for (int s = 1; s <= 4; s++) begin
                int c;
                c = (mptr + s) % 4;
                if (owner < 0 && pos[c] < tail[c]) owner = c;
            end
            if (owner < 0) break;
`ifdef UART_TX_ARB_HDR_EN
            exp_d.push_back(8'hA0 | 8'(owner));
            exp_g.push_back(4'(1 << owner));
`endif
            do begin
                exp_d.push_back(m_d[owner][pos[owner]]);
                exp_g.push_back(4'(1 << owner));
                lst = m_l[owner][pos[owner]];
                pos[owner]++;
            end while (!lst && pos[owner] < tail[owner]);
            mptr = owner;
        end
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        bit empty;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            empty = 1'b1;
            for (int i = 0; i < 4; i++) if (head[i] < tail[i]) empty = 1'b0;
            if (empty && grant === 4'b0 && tx_vld === 1'b0 && obs_d.size() >= exp_d.size()) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; busy = 1'b0; req_vld = '0; req_last = '0; req_data = '0;
        clear_all();
        mptr = 3;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx_data got=%h want=00", tx_data);
        end
        for (int n = 0; n < 20; n++) begin
            checks++;
            if (grant !== 4'b0 || tx_vld !== 1'b0 || req_rdy !== 4'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d grant=%b vld=%b rdy=%b want 0000/0/0000", n, grant, tx_vld, req_rdy);
            end
            tick();
        end
    endtask

    task automatic test_single_stream();
        bit ok;
        clear_all();
        push_byte(1, 8'h24, 1'b0);
        push_byte(1, 8'hAA, 1'b0);
        push_byte(1, 8'h55, 1'b1);
        build_expected();
        drive();
        #1;
        run_until_done(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout obs=%0d want=%0d", obs_d.size(), exp_d.size()); end
        checks++;
        if (obs_d.size() !== exp_d.size()) begin
            failures++; $display("FAIL single_count got=%0d want=%0d", obs_d.size(), exp_d.size());
        end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== exp_d[k] || obs_g[k] !== exp_g[k]) begin
                failures++; $display("FAIL single_byte k=%0d got=%h/%b want=%h/%b", k, obs_d[k], obs_g[k], exp_d[k], exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (obs_c[k] - obs_c[k-1] !== 2) begin
                    failures++; $display("FAIL single_spacing k=%0d got=%0d want=2", k, obs_c[k] - obs_c[k-1]);
                end
            end
        end
        checks++;
        if (grant !== 4'b0) begin failures++; $display("FAIL single_release got=%b want=0000", grant); end
    endtask

    task automatic test_header();
        bit ok;
        clear_all();
        push_byte(3, 8'h24, 1'b1);
        build_expected();
        drive();
        #1;
        run_until_done(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL header_timeout obs=%0d", obs_d.size()); end
        checks++;
`ifdef UART_TX_ARB_HDR_EN
        if (obs_d.size() !== 2 || obs_d[0] !== 8'hA3 || obs_d[1] !== 8'h24) begin
            failures++; $display("FAIL header_stream n=%0d first=%h want A3,24", obs_d.size(), obs_d.size() > 0 ? obs_d[0] : 8'hxx);
        end
`else
        if (obs_d.size() !== 1 || obs_d[0] !== 8'h24) begin
            failures++; $display("FAIL header_stream n=%0d first=%h want 24 only", obs_d.size(), obs_d.size() > 0 ? obs_d[0] : 8'hxx);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_all();
        push_byte(0, 8'h10, 1'b0); push_byte(0, 8'h11, 1'b1);
        push_byte(0, 8'h12, 1'b0); push_byte(0, 8'h13, 1'b1);
        push_byte(2, 8'h20, 1'b0); push_byte(2, 8'h21, 1'b1);
        build_expected();
        drive();
        #1;
        run_until_done(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_timeout obs=%0d want=%0d", obs_d.size(), exp_d.size()); end
        checks++;
        if (obs_d.size() !== exp_d.size()) begin
            failures++; $display("FAIL b2b_count got=%0d want=%0d", obs_d.size(), exp_d.size());
        end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== exp_d[k] || obs_g[k] !== exp_g[k]) begin
                failures++; $display("FAIL b2b_byte k=%0d got=%h/%b want=%h/%b", k, obs_d[k], obs_g[k], exp_d[k], exp_g[k]);
            end
        end
        checks++;
        if (b2b_err !== 0) begin failures++; $display("FAIL b2b_adjacent_pulses got=%0d want=0", b2b_err); end
    endtask

    task automatic test_random();
        bit ok;
        for (int round = 0; round < 4; round++) begin
            clear_all();
            for (int r = 0; r < 4; r++) begin
                int nmsg;
                nmsg = $urandom_range(2);
                for (int m = 0; m < nmsg; m++) begin
                    int len;
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
                end
            end
            build_expected();
            rand_busy = (round >= 2);
            drive();
            #1;
            run_until_done(1000, ok);
            rand_busy = 1'b0;
            busy = 1'b0;
            checks++;
            if (!ok) begin failures++; $display("FAIL random_timeout round=%0d obs=%0d want=%0d", round, obs_d.size(), exp_d.size()); end
            checks++;
            if (obs_d.size() !== exp_d.size()) begin
                failures++; $display("FAIL random_count round=%0d got=%0d want=%0d", round, obs_d.size(), exp_d.size());
            end
            for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
                checks++;
                if (obs_d[k] !== exp_d[k] || obs_g[k] !== exp_g[k]) begin
                    failures++; $display("FAIL random_byte round=%0d k=%0d got=%h/%b want=%h/%b", round, k, obs_d[k], obs_g[k], exp_d[k], exp_g[k]);
                end
            end
            checks++;
            if (b2b_err !== 0) begin failures++; $display("FAIL random_adjacent_pulses round=%0d got=%0d want=0", round, b2b_err); end
        end
    endtask

    task automatic test_busy();
        bit ok;
        int c0;
        int rdy_bad;
        clear_all();
        busy = 1'b1;
        push_byte(2, 8'h5C, 1'b0);
        push_byte(2, 8'hC5, 1'b1);
        build_expected();
        drive();
        #1;
        for (int n = 0; n < 10 && grant === 4'b0; n++) tick();
        checks++;
        if (grant !== 4'b0100) begin failures++; $display("FAIL busy_grant got=%b want=0100", grant); end
        rdy_bad = 0;
        for (int n = 0; n < 50; n++) begin
            if (req_rdy !== 4'b0) rdy_bad++;
            tick();
        end
        checks++;
        if (rdy_bad !== 0) begin failures++; $display("FAIL busy_rdy cycles_high=%0d want=0", rdy_bad); end
        checks++;
        if (obs_d.size() !== 0) begin failures++; $display("FAIL busy_no_pulse got=%0d pulses want=0", obs_d.size()); end
        busy = 1'b0;
        #1;
        c0 = cyc;
        for (int n = 0; n < 4 && obs_d.size() == 0; n++) tick();
        checks++;
        if (obs_d.size() == 0 || obs_c[0] - c0 < 1 || obs_c[0] - c0 > 2 || obs_d[0] !== exp_d[0]) begin
            failures++;
            $display("FAIL busy_release n=%0d delay=%0d data=%h want data=%h within 2", obs_d.size(),
                     obs_d.size() > 0 ? obs_c[0] - c0 : -1, obs_d.size() > 0 ? obs_d[0] : 8'hxx, exp_d[0]);
        end
        run_until_done(50, ok);
        checks++;
        if (!ok || obs_d.size() !== exp_d.size()) begin
            failures++; $display("FAIL busy_drain got=%0d want=%0d", obs_d.size(), exp_d.size());
        end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== exp_d[k]) begin
                failures++; $display("FAIL busy_byte k=%0d got=%h want=%h", k, obs_d[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int want_n;
        int n_at_rst;
        clear_all();
        push_byte(2, 8'h01, 1'b0);
        push_byte(2, 8'h02, 1'b0);
        push_byte(2, 8'h03, 1'b1);
`ifdef UART_TX_ARB_HDR_EN
        want_n = 2;
`else
        want_n = 1;
`endif
        drive();
        #1;
        for (int n = 0; n < 30 && obs_d.size() < want_n; n++) tick();
        checks++;
        if (obs_d.size() !== want_n || obs_d[want_n-1] !== 8'h01) begin
            failures++; $display("FAIL rstmid_first n=%0d want=%0d byte 01", obs_d.size(), want_n);
        end
        rst = 1'b1;
        head[2] = tail[2];
        drive();
        #1;
        n_at_rst = obs_d.size();
        tick();
        rst = 1'b0;
        mptr = 3;
        checks++;
        if (grant !== 4'b0 || tx_vld !== 1'b0 || tx_data !== 8'h00) begin
            failures++; $display("FAIL rstmid_after grant=%b vld=%b data=%h want 0000/0/00", grant, tx_vld, tx_data);
        end
        repeat (10) tick();
        checks++;
        if (obs_d.size() !== n_at_rst) begin
            failures++; $display("FAIL rstmid_extra_pulse got=%0d want=%0d", obs_d.size(), n_at_rst);
        end
        clear_all();
        push_byte(1, 8'h5A, 1'b1);
        push_byte(0, 8'hC3, 1'b1);
        build_expected();
        drive();
        #1;
        run_until_done(100, ok);
        checks++;
        if (!ok || obs_d.size() !== exp_d.size()) begin
            failures++; $display("FAIL rstmid_drain got=%0d want=%0d", obs_d.size(), exp_d.size());
        end
        checks++;
        if (obs_g.size() == 0 || obs_g[0] !== 4'b0001) begin
            failures++; $display("FAIL rstmid_winner got=%b want=0001", obs_g.size() > 0 ? obs_g[0] : 4'bxxxx);
        end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== exp_d[k] || obs_g[k] !== exp_g[k]) begin
                failures++; $display("FAIL rstmid_byte k=%0d got=%h/%b want=%h/%b", k, obs_d[k], obs_g[k], exp_d[k], exp_g[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_header();
        test_back_to_back();
        test_busy();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters sharing the UART transmit path; legal range 2..16.
REQ-002 clk_i  input  1  single clock; all logic rising-edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 req_data_i  input  NUM_REQ x 8  per-requester data byte.
REQ-005 req_vld_i  input  NUM_REQ  per-requester byte valid.
REQ-006 req_last_i  input  NUM_REQ  marks the final byte of a message; qualified by req_vld_i.
REQ-007 req_rdy_o  output  NUM_REQ  per-requester byte accept.
REQ-008 tx_data_o  output  8  byte to uart_top tx_data_i.
REQ-009 tx_data_vld_o  output  1  one-cycle write pulse to uart_top tx_data_vld_i.
REQ-010 tx_busy_i  input  1  from uart_top tx_busy_o; 1 = transmit path cannot accept a byte.
REQ-011 grant_o  output  NUM_REQ  one-hot current owner; all-zero when idle.

Function
REQ-012 The FSM SHALL have states IDLE, HDR, SEND, GAP.
REQ-013 IDLE: when any req_vld_i=1, the block SHALL select a winner round-robin, starting at the index after the last-granted one and wrapping; grant_o is registered and asserts 1 cycle after req_vld_i; next state is HDR when UART_TX_ARB_HDR_EN is defined, otherwise SEND.
REQ-014 The grant SHALL be held until the byte with req_last_i=1 is accepted; other requesters see req_rdy_o=0 throughout.
REQ-015 SEND: req_rdy_o[g]=1 (combinational) iff the state is SEND and tx_busy_i=0; a handshake is req_vld_i[g] & req_rdy_o[g].
REQ-016 On handshake at cycle T: tx_data_o=req_data_i[g] and tx_data_vld_o=1 during T+1 (registered); the state is GAP during T+1.
REQ-017 GAP SHALL last exactly 1 cycle; it then goes to SEND, or to IDLE with grant_o=0 if the byte was last; the pointer updates to g.
REQ-018 tx_data_vld_o SHALL never be high on two consecutive cycles; tx_busy_i must reflect a pulse by the following cycle (uart_top contract).
REQ-019 tx_data_o SHALL hold its last value when tx_data_vld_o=0.
REQ-020 If the granted req_vld_i drops mid-message, the block SHALL hold the grant in SEND indefinitely (no timeout).
REQ-021 For a single-byte message (vld and last in the same cycle), the cost SHALL be IDLE->[HDR->GAP->]SEND->GAP->IDLE.
REQ-022 Simultaneous requests SHALL be served in round-robin order; a requester re-asserting immediately after its own last byte SHALL lose to any other pending requester.

Reset
REQ-023 On the rst_i edge: state=IDLE, grant_o=0, tx_data_vld_o=0, tx_data_o=8'h00, req_rdy_o=0, pointer=NUM_REQ-1 (requester 0 has first priority).
REQ-024 Reset mid-message SHALL abandon the message with no further pulse; the requester must restart the message.

Configuration
REQ-025 Macro UART_TX_ARB_HDR_EN defined: after a grant, HDR waits for tx_busy_i=0, then issues one pulse with tx_data_o={4'hA, g[3:0]}, then GAP, then SEND.
REQ-026 Macro UART_TX_ARB_HDR_EN undefined: the HDR state and header logic are absent; the grant goes directly to SEND.

Structure
REQ-027 Package uart_arb_pkg SHALL hold the FSM state enum, HDR_TAG=4'hA and NUM_REQ_MAX=16.
REQ-028 Sub-module uart_rr_pick SHALL contain the combinational round-robin winner search (inputs: request vector and pointer; outputs: one-hot winner and its index).

Verification
REQ-029 Reset, no requests -> grant_o=0, tx_data_vld_o=0, req_rdy_o=0 for 20 cycles.
REQ-030 Requester 1 sends 3 bytes 8'h24, 8'hAA, 8'h55 (last on 8'h55), tx_busy_i=0 -> three single-cycle pulses spaced 2 cycles apart in order; grant_o=4'b0010 throughout, then 0.
REQ-031 Requesters 0 and 2 request simultaneously with 2-byte messages -> all of 0's bytes, then all of 2's bytes, with no interleaving; the next contest from {0,2} goes to 2.
REQ-032 tx_busy_i held at 1 for 50 cycles during SEND -> req_rdy_o=0 and no pulse; a byte issues 2 cycles after tx_busy_i falls.
REQ-033 With UART_TX_ARB_HDR_EN, requester 3 sends 8'h24 -> pulses 8'hA3 then 8'h24; without the macro -> only 8'h24.
REQ-034 rst_i asserted mid-message after byte 1 of 3 -> no further pulses, grant_o=0 on the next cycle, and requester 0 wins the next contest.
